// File: rtl/branch_feedback_queue_pkg.sv
// Shared types and constants for the branch feedback queue and its neighbours
// (fetch predictor and ALU/branch unit).
package branch_feedback_queue_pkg;

  typedef logic [31:0] ADDR_TP;
  typedef logic [31:0] WORD_TP;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Fall-through distance for a not-taken branch.
  localparam ADDR_TP NEXT_PC_INC = 32'd4;

  localparam int BFQ_TAG_W = 3;
  typedef logic [BFQ_TAG_W-1:0] BFQ_TAG_TP;

  typedef enum logic {
    BFQ_NORMAL = 1'b0,
    BFQ_FLUSH  = 1'b1
  } bfq_state_e;

endpackage

// File: rtl/branch_feedback_queue.sv
// In-order branch prediction queue: allocated by fetch, resolved out of order
// by execute, retired in program order into the predictor update / flush port.
module branch_feedback_queue
  import branch_feedback_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_ena,
  input  logic [31:0]      alloc_pc,
  input  logic             alloc_pred_tk,
  input  logic [31:0]      alloc_pred_tgt,
  output logic             alloc_rdy,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             rs_ena,
  input  logic [TAG_W-1:0] rs_tag,
  input  logic             rs_tk,
  input  logic [31:0]      rs_tgt,
  output logic             fb_ena,
  output logic             fb_tk,
  output logic [31:0]      fb_pc,
  output logic             flush,
  output logic [31:0]      redirect_pc
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

  logic   valid_q    [DEPTH];
  logic   valid_d    [DEPTH];
  logic   resolved_q [DEPTH];
  logic   resolved_d [DEPTH];
  ADDR_TP pc_q       [DEPTH];
  ADDR_TP pc_d       [DEPTH];
  logic   pred_tk_q  [DEPTH];
  logic   pred_tk_d  [DEPTH];
  ADDR_TP pred_tgt_q [DEPTH];
  ADDR_TP pred_tgt_d [DEPTH];
  logic   act_tk_q   [DEPTH];
  logic   act_tk_d   [DEPTH];
  ADDR_TP act_tgt_q  [DEPTH];
  ADDR_TP act_tgt_d  [DEPTH];

  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  bfq_state_e       state_q, state_d;

  logic   fb_ena_q, fb_ena_d, fb_tk_q, fb_tk_d, flush_q, flush_d;
  ADDR_TP fb_pc_q, fb_pc_d, redirect_pc_q, redirect_pc_d;

  logic in_normal, alloc_fire, rs_fire, retire, mispredict;

  assign in_normal = (state_q == BFQ_NORMAL);
  assign alloc_rdy = (count_q != FULL_COUNT) && in_normal;
  assign alloc_tag = tail_q;

  assign alloc_fire = alloc_ena && alloc_rdy;
  assign rs_fire    = rs_ena && valid_q[rs_tag] && in_normal;
  // Retirement looks only at pre-edge state, so a same-cycle resolve of the
  // head entry cannot shortcut the one-cycle resolve-to-retire latency.
  assign retire     = in_normal && valid_q[head_q] && resolved_q[head_q];
  assign mispredict = retire &&
                      ((act_tk_q[head_q] != pred_tk_q[head_q]) ||
                       (act_tk_q[head_q] && (act_tgt_q[head_q] != pred_tgt_q[head_q])));

  always_comb begin
    valid_d       = valid_q;
    resolved_d    = resolved_q;
    pc_d          = pc_q;
    pred_tk_d     = pred_tk_q;
    pred_tgt_d    = pred_tgt_q;
    act_tk_d      = act_tk_q;
    act_tgt_d     = act_tgt_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire);
    state_d       = BFQ_NORMAL;
    fb_ena_d      = FALSE;
    fb_tk_d       = fb_tk_q;
    fb_pc_d       = fb_pc_q;
    flush_d       = FALSE;
    redirect_pc_d = redirect_pc_q;

    if (rs_fire) begin
      resolved_d[rs_tag] = TRUE;
      act_tk_d[rs_tag]   = rs_tk;
      act_tgt_d[rs_tag]  = rs_tgt;
    end

    if (alloc_fire) begin
      valid_d[tail_q]    = TRUE;
      resolved_d[tail_q] = FALSE;
      pc_d[tail_q]       = alloc_pc;
      pred_tk_d[tail_q]  = alloc_pred_tk;
      pred_tgt_d[tail_q] = alloc_pred_tgt;
      tail_d             = tail_q + TAG_W'(1);
    end

    if (retire) begin
      valid_d[head_q]    = FALSE;
      resolved_d[head_q] = FALSE;
      head_d             = head_q + TAG_W'(1);
      fb_ena_d           = TRUE;
      fb_tk_d            = act_tk_q[head_q];
      fb_pc_d            = pc_q[head_q];
    end

    // A mispredict squashes every younger entry, including anything
    // allocated or resolved on this same edge.
    if (mispredict) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_d[i]    = FALSE;
        resolved_d[i] = FALSE;
      end
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      state_d       = BFQ_FLUSH;
      flush_d       = TRUE;
      redirect_pc_d = act_tk_q[head_q] ? act_tgt_q[head_q] : pc_q[head_q] + NEXT_PC_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]    <= FALSE;
        resolved_q[i] <= FALSE;
        pc_q[i]       <= '0;
        pred_tk_q[i]  <= FALSE;
        pred_tgt_q[i] <= '0;
        act_tk_q[i]   <= FALSE;
        act_tgt_q[i]  <= '0;
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      state_q       <= BFQ_NORMAL;
      fb_ena_q      <= FALSE;
      fb_tk_q       <= FALSE;
      fb_pc_q       <= '0;
      flush_q       <= FALSE;
      redirect_pc_q <= '0;
    end else if (rdy) begin
      valid_q       <= valid_d;
      resolved_q    <= resolved_d;
      pc_q          <= pc_d;
      pred_tk_q     <= pred_tk_d;
      pred_tgt_q    <= pred_tgt_d;
      act_tk_q      <= act_tk_d;
      act_tgt_q     <= act_tgt_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      state_q       <= state_d;
      fb_ena_q      <= fb_ena_d;
      fb_tk_q       <= fb_tk_d;
      fb_pc_q       <= fb_pc_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign fb_ena      = fb_ena_q;
  assign fb_tk       = fb_tk_q;
  assign fb_pc       = fb_pc_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_branch_feedback_queue.sv
// Randomized scoreboard bench for branch_feedback_queue against a queue-based
// program-order model.
module tb_branch_feedback_queue;

  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  logic             clk, rst, rdy;
  logic             alloc_ena, alloc_pred_tk, alloc_rdy;
  logic [31:0]      alloc_pc, alloc_pred_tgt;
  logic [TAG_W-1:0] alloc_tag, rs_tag;
  logic             rs_ena, rs_tk;
  logic [31:0]      rs_tgt;
  logic             fb_ena, fb_tk, flush;
  logic [31:0]      fb_pc, redirect_pc;

  branch_feedback_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_ena(alloc_ena), .alloc_pc(alloc_pc), .alloc_pred_tk(alloc_pred_tk),
    .alloc_pred_tgt(alloc_pred_tgt), .alloc_rdy(alloc_rdy), .alloc_tag(alloc_tag),
    .rs_ena(rs_ena), .rs_tag(rs_tag), .rs_tk(rs_tk), .rs_tgt(rs_tgt),
    .fb_ena(fb_ena), .fb_tk(fb_tk), .fb_pc(fb_pc),
    .flush(flush), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order model: oldest branch at the front of the queue.
  typedef struct {
    int          tag;
    logic [31:0] pc;
    bit          ptk;
    logic [31:0] ptgt;
    bit          res;
    bit          atk;
    logic [31:0] atgt;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    bit          tk;
    bit          mis;
    logic [31:0] redir;
  } fb_t;

  ent_t        mq[$];
  fb_t         sbq[$];
  int          m_next_tag = 0;
  bit          m_flush = 0;
  bit          e_fb_ena = 0, e_flush = 0, last_rdy_edge = 0;
  logic [31:0] e_redirect = '0;

  always @(posedge clk) begin : model
    bit   ret, mis;
    ent_t h, n;
    if (rst) begin
      mq.delete(); sbq.delete();
      m_next_tag = 0; m_flush = 0; e_fb_ena = 0; e_flush = 0;
      e_redirect = '0; last_rdy_edge = 0;
    end else begin
      last_rdy_edge = rdy;
      if (rdy) begin
        ret = (mq.size() > 0) && mq[0].res;
        mis = 0;
        if (ret) h = mq[0];
        if (!m_flush) begin
          if (rs_ena)
            foreach (mq[i])
              if (mq[i].tag == int'(rs_tag)) begin
                mq[i].res = 1; mq[i].atk = rs_tk; mq[i].atgt = rs_tgt;
              end
          if (alloc_ena && mq.size() < DEPTH) begin
            n.tag = m_next_tag; n.pc = alloc_pc; n.ptk = alloc_pred_tk;
            n.ptgt = alloc_pred_tgt; n.res = 0; n.atk = 0; n.atgt = '0;
            mq.push_back(n);
            m_next_tag = (m_next_tag + 1) % DEPTH;
          end
        end
        if (ret) begin
          void'(mq.pop_front());
          mis = (h.atk != h.ptk) || (h.atk && h.atgt != h.ptgt);
          if (mis) begin
            e_redirect = h.atk ? h.atgt : h.pc + 32'd4;
            mq.delete();
            m_next_tag = 0;
          end
          sbq.push_back('{h.pc, h.atk, mis, e_redirect});
        end
        e_fb_ena = ret;
        e_flush  = mis;
        m_flush  = mis;
      end
    end
  end

  // Monitor: flag levels every cycle, scoreboard contents on each fresh strobe.
  always @(negedge clk) begin : monitor
    fb_t f;
    if (!rst) begin
      chk("fb_ena_level", 32'(fb_ena), 32'(e_fb_ena));
      chk("flush_level", 32'(flush), 32'(e_flush));
      if (last_rdy_edge) begin
        if (fb_ena) begin
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL fb_unexpected: got fb_pc 0x%08h expected no update", fb_pc);
          end else begin
            f = sbq.pop_front();
            chk("fb_pc", fb_pc, f.pc);
            chk("fb_tk", 32'(fb_tk), 32'(f.tk));
            chk("flush_with_fb", 32'(flush), 32'(f.mis));
            if (f.mis) chk("redirect_pc", redirect_pc, f.redir);
          end
        end else if (sbq.size() > 0) begin
          f = sbq.pop_front();
          checks++; errors++;
          $display("FAIL fb_missing: got no update expected fb_pc 0x%08h", f.pc);
        end
      end
    end
  end

  task automatic step(input bit ae, input logic [31:0] apc, input bit aptk,
                      input logic [31:0] aptgt, input bit re, input logic [TAG_W-1:0] tag,
                      input bit tk, input logic [31:0] tgt, input bit r);
    alloc_ena = ae; alloc_pc = apc; alloc_pred_tk = aptk; alloc_pred_tgt = aptgt;
    rs_ena = re; rs_tag = tag; rs_tk = tk; rs_tgt = tgt; rdy = r;
    if (!rst) begin
      chk("alloc_rdy", 32'(alloc_rdy), 32'((mq.size() != DEPTH) && !m_flush));
      chk("alloc_tag", 32'(alloc_tag), 32'(m_next_tag));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit r = 1'b1);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, '0, 0, '0, r);
  endtask

  task automatic alloc_one(input logic [31:0] pc, input bit ptk, input logic [31:0] ptgt);
    step(1, pc, ptk, ptgt, 0, '0, 0, '0, 1);
  endtask

  task automatic resolve_one(input logic [TAG_W-1:0] tag, input bit tk,
                             input logic [31:0] tgt, input bit r = 1'b1);
    step(0, '0, 0, '0, 1, tag, tk, tgt, r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; alloc_ena = 0; alloc_pc = '0; alloc_pred_tk = 0;
    alloc_pred_tgt = '0; rs_ena = 0; rs_tag = '0; rs_tk = 0; rs_tgt = '0;
    @(negedge clk);
    do_reset();
    chk("reset_alloc_rdy", 32'(alloc_rdy), 32'd1);
    chk("reset_alloc_tag", 32'(alloc_tag), 32'd0);
    chk("reset_fb_ena", 32'(fb_ena), 32'd0);
    chk("reset_flush", 32'(flush), 32'd0);
    chk("reset_fb_pc", fb_pc, 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);

    // Correct prediction.
    alloc_one(32'h100, 1, 32'h140);
    resolve_one(0, 1, 32'h140);
    idle(3);

    // Out-of-order resolution, in-order retirement.
    do_reset();
    alloc_one(32'h10, 0, 32'h14);
    alloc_one(32'h20, 0, 32'h24);
    alloc_one(32'h30, 0, 32'h34);
    resolve_one(2, 0, 32'h34);
    resolve_one(1, 0, 32'h24);
    idle(2);
    resolve_one(0, 0, 32'h14);
    idle(4);

    // Mispredict: younger tag1 is squashed.
    do_reset();
    alloc_one(32'h200, 0, 32'h204);
    alloc_one(32'h300, 0, 32'h304);
    resolve_one(0, 1, 32'h280);
    idle(1);
    chk("mispredict_redirect", redirect_pc, 32'h280);
    idle(1);
    resolve_one(1, 0, 32'h304);
    idle(3);

    // Full, dropped ninth allocation, wrap of the tail.
    do_reset();
    for (int i = 0; i < 9; i++) alloc_one(32'h1000 + 32'(i) * 16, 0, 32'h1004 + 32'(i) * 16);
    resolve_one(0, 0, 32'h1004);
    idle(2);
    chk("wrap_alloc_tag", 32'(alloc_tag), 32'd0);

    // Stall with a resolve presented while rdy is low.
    resolve_one(1, 0, 32'h1014);
    idle(1);
    idle(1, 0);
    resolve_one(2, 0, 32'h1024, 0);
    idle(1, 0);
    resolve_one(2, 0, 32'h1024);
    idle(3);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bit          ae, aptk, re, tk, r;
      logic [31:0] apc, aptgt, tgt;
      logic [TAG_W-1:0] tag;
      int          idx;
      r    = ($urandom_range(0, 9) != 0);
      ae   = $urandom_range(0, 1);
      apc  = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      aptk = $urandom_range(0, 1);
      aptgt = aptk ? {$urandom_range(0, 32'h3fff_ffff), 2'b00} : apc + 32'd4;
      re   = $urandom_range(0, 1);
      tag  = TAG_W'($urandom_range(0, DEPTH - 1));
      tk   = $urandom_range(0, 1);
      tgt  = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      if (mq.size() > 0 && $urandom_range(0, 9) < 8) begin
        idx = $urandom_range(0, mq.size() - 1);
        tag = TAG_W'(mq[idx].tag);
        tk  = ($urandom_range(0, 19) == 0) ? !mq[idx].ptk : mq[idx].ptk;
        if (tk && mq[idx].ptk && $urandom_range(0, 19) != 0) tgt = mq[idx].ptgt;
      end
      step(ae, apc, aptk, aptgt, re, tag, tk, tgt, r);
    end
    idle(4);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
